// File: rtl/mul12u_approx_mac_pkg.sv
// Shared types and helpers for the truncated approximate multiply-accumulate block.
//   state_e  : controller states (ACCUM, DRAIN, DONE)
//   DEF_*    : default geometry of the 12x12 approximate multiplier
//   clog2    : ceiling log2, usable in constant expressions
package mul_approx_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_W     = 12;
  localparam int DEF_TRUNC = 4;
  localparam int PROD_W    = 2 * DEF_W;
  localparam int TRUNC_SH  = 2 * DEF_TRUNC;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mul12u_approx_mac_trunc_core.sv
// Combinational W x W unsigned approximate multiplier.
// The TRUNC low bits of each operand are dropped, the remaining high parts are
// multiplied exactly, and the result is shifted back by 2*TRUNC, so the low
// 2*TRUNC product bits are always zero. No rounding or compensation term.
//   a, b : operands (W bits, unsigned)
//   p    : approximate product (2*W bits)
module mul_trunc_core #(
  parameter int W     = 12,
  parameter int TRUNC = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  localparam int HW = W - TRUNC;

  logic [2*HW-1:0] prod_high;
  logic [2*W-1:0]  prod_ext;

  assign prod_high = a[W-1:TRUNC] * b[W-1:TRUNC];
  assign prod_ext  = (2*W)'(prod_high);
  assign p         = prod_ext << (2 * TRUNC);

endmodule

// File: rtl/mul12u_approx_mac.sv
// Accumulation stage for the truncated approximate multiplier.
// Operand pairs arrive on a valid/ready stream, pass through a two-register
// product pipeline and are summed into a group accumulator. A group closes on
// in_last or after ACC_LEN products; the sum is then offered on out_*.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand stream handshake
//   in_a, in_b, in_last  : operands and early group close
//   out_valid/out_ready  : group sum handshake
//   out_sum, out_count   : group sum and number of products in it
module mul12u_approx_mac
  import mul_approx_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TRUNC   = DEF_TRUNC,
  parameter int ACC_LEN = 16,
  parameter int ACC_W   = 28,
  localparam int CW     = clog2(ACC_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count
);

  localparam int HW = W - TRUNC;
  localparam int PW = 2 * W;

  // The accumulator must hold ACC_LEN full-scale products without wrapping.
  if (ACC_W < PW + clog2(ACC_LEN)) begin : g_acc_width_check
    $error("mul12u_approx_mac: ACC_W too small for ACC_LEN products");
  end

  state_e         state;
  logic           dcnt;
  logic [HW-1:0]  a_h;
  logic [HW-1:0]  b_h;
  logic           v1;
  logic           v2;
  logic [PW-1:0]  p_comb;
  logic [PW-1:0]  p_reg;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic accept;
  logic close_group;

  assign accept      = in_valid & in_ready;
  assign close_group = in_last | (cnt == CW'(ACC_LEN - 1));

  // Stage-1 registers hold only the kept operand bits; re-extend to W for the core.
  mul_trunc_core #(
    .W     (W),
    .TRUNC (TRUNC)
  ) u_core (
    .a ({a_h, {TRUNC{1'b0}}}),
    .b ({b_h, {TRUNC{1'b0}}}),
    .p (p_comb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      dcnt      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      a_h       <= '0;
      b_h       <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      p_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      // Product pipeline: operand capture, product register, accumulate.
      v1 <= accept;
      if (accept) begin
        a_h <= in_a[W-1:TRUNC];
        b_h <= in_b[W-1:TRUNC];
      end
      v2    <= v1;
      p_reg <= p_comb;
      if (v2) begin
        acc <= acc + ACC_W'(p_reg);
      end

      case (state)
        ACCUM: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (close_group) begin
              state    <= DRAIN;
              dcnt     <= 1'b0;
              in_ready <= 1'b0;
            end
          end
        end
        // Two cycles let the last accepted pair reach the accumulator.
        DRAIN: begin
          if (dcnt) begin
            state <= DONE;
          end else begin
            dcnt <= 1'b1;
          end
        end
        // First DONE cycle latches the finished sum; then hold until taken.
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_sum   <= acc;
            out_count <= cnt;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            state     <= ACCUM;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul12u_approx_mac.sv
module tb_mul12u_approx_mac;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_sum;
  logic [4:0]  out_count;

  int checks = 0;
  int errors = 0;

  mul12u_approx_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] golden(input logic [11:0] a, input logic [11:0] b);
    logic [27:0] ah;
    logic [27:0] bh;
    ah = 28'(a >> 4);
    bh = 28'(b >> 4);
    return (ah * bh) << 8;
  endfunction

  // Present one pair, wait for the accepting edge; returns cycles taken.
  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic last,
                      output int cyc);
    logic rdy;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    cyc = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      cyc++;
    end while (!rdy && cyc < 50);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never high, waited %0d cycles (required < 50)", cyc);
    end
  endtask

  // Wait (bounded) for out_valid; returns at the negedge where it is seen.
  task automatic wait_result(output int lat, output logic ready_seen);
    lat = 0;
    ready_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) ready_seen = 1'b1;
      lat++;
      if (lat > 100) begin
        checks++;
        errors++;
        $display("FAIL result_timeout: out_valid=%0b after %0d cycles (required 1)", out_valid, lat);
        break;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 28'h0 || out_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_sum=%h out_count=%0d (required 1 0 0 0)",
               in_ready, out_valid, out_sum, out_count);
    end
    $display("reset: in_ready=%0b out_valid=%0b out_sum=%h out_count=%0d", in_ready, out_valid, out_sum, out_count);
  endtask

  task automatic test_full_group();
    int cyc, maxcyc, lat;
    logic rs;
    @(posedge clk); #1;
    maxcyc = 0;
    for (int i = 0; i < 16; i++) begin
      send(12'hFFF, 12'hFFF, 1'b0, cyc);
      if (cyc > maxcyc) maxcyc = cyc;
    end
    wait_result(lat, rs);
    checks++;
    if (maxcyc !== 1) begin
      errors++;
      $display("FAIL full_back_to_back: max accept cycles=%0d (required 1)", maxcyc);
    end
    checks++;
    if (out_sum !== 28'h0FE01000 || out_count !== 5'd16) begin
      errors++;
      $display("FAIL full_group: out_sum=%h out_count=%0d (required 0fe01000 16)", out_sum, out_count);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL full_latency: latency=%0d (required 3)", lat);
    end
    $display("full group: out_sum=%h out_count=%0d latency=%0d", out_sum, out_count, lat);
    release_result();
  endtask

  task automatic test_single(input logic [11:0] a, input logic [11:0] b, input logic [27:0] exp_sum,
                             input string name);
    int cyc, lat;
    logic rs;
    @(posedge clk); #1;
    send(a, b, 1'b1, cyc);
    wait_result(lat, rs);
    checks++;
    if (out_sum !== exp_sum || out_count !== 5'd1) begin
      errors++;
      $display("FAIL %s: out_sum=%h out_count=%0d (required %h 1)", name, out_sum, out_count, exp_sum);
    end
    checks++;
    if (out_sum !== golden(a, b) || out_sum[7:0] !== 8'h00) begin
      errors++;
      $display("FAIL %s_golden: out_sum=%h (required model %h, low byte 0)", name, out_sum, golden(a, b));
    end
    $display("single %s: a=%h b=%h out_sum=%h out_count=%0d", name, a, b, out_sum, out_count);
    release_result();
  endtask

  task automatic test_last_early();
    int cyc, lat;
    logic rs;
    @(posedge clk); #1;
    send(12'h100, 12'h100, 1'b0, cyc);
    send(12'h100, 12'h100, 1'b0, cyc);
    send(12'h100, 12'h100, 1'b1, cyc);
    // Garbage offered while draining must not be taken.
    in_valid = 1'b1; in_a = 12'hFFF; in_b = 12'hFFF;
    wait_result(lat, rs);
    checks++;
    if (rs !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_ready: in_ready seen high=%0b now=%0b (required 0 0)", rs, in_ready);
    end
    checks++;
    if (out_sum !== 28'h0030000 || out_count !== 5'd3) begin
      errors++;
      $display("FAIL last_early: out_sum=%h out_count=%0d (required 0030000 3)", out_sum, out_count);
    end
    $display("early last: out_sum=%h out_count=%0d", out_sum, out_count);
    in_valid = 1'b0;
    release_result();
  endtask

  task automatic test_hold_done();
    int cyc, lat;
    logic rs;
    logic [27:0] s0;
    logic bad;
    @(posedge clk); #1;
    send(12'h0A0, 12'h050, 1'b0, cyc);
    send(12'h020, 12'h030, 1'b1, cyc);
    wait_result(lat, rs);
    s0 = out_sum;
    checks++;
    if (s0 !== 28'h0003800) begin
      errors++;
      $display("FAIL hold_sum: out_sum=%h (required 0003800)", s0);
    end
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_sum !== s0 || out_count !== 5'd2 || in_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stable: out_valid=%0b out_sum=%h out_count=%0d in_ready=%0b (required 1 %h 2 0)",
               out_valid, out_sum, out_count, in_ready, s0);
    end
    @(posedge clk); #1;
    release_result();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: in_ready=%0b out_valid=%0b (required 1 0)", in_ready, out_valid);
    end
    $display("hold done: out_sum=%h released in_ready=%0b", s0, in_ready);
  endtask

  task automatic test_ready_early();
    int cyc, lat;
    logic rs;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(12'h100, 12'h200, 1'b1, cyc);
    wait_result(lat, rs);
    checks++;
    if (out_sum !== 28'h0020000 || out_count !== 5'd1 || lat !== 3) begin
      errors++;
      $display("FAIL ready_early: out_sum=%h out_count=%0d latency=%0d (required 0020000 1 3)",
               out_sum, out_count, lat);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_early_handshake: out_valid=%0b in_ready=%0b (required 0 1)", out_valid, in_ready);
    end
    out_ready = 1'b0;
    $display("early out_ready: out_sum=%h handshake done", out_sum);
  endtask

  task automatic test_reset_mid_group();
    int cyc, lat;
    logic rs;
    logic pulse;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(12'hFFF, 12'hFFF, 1'b0, cyc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulse = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) pulse = 1'b1;
    end
    checks++;
    if (pulse || in_ready !== 1'b1 || out_sum !== 28'h0 || out_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: pulse=%0b in_ready=%0b out_sum=%h out_count=%0d (required 0 1 0 0)",
               pulse, in_ready, out_sum, out_count);
    end
    @(posedge clk); #1;
    send(12'h010, 12'h010, 1'b0, cyc);
    send(12'h010, 12'h010, 1'b1, cyc);
    wait_result(lat, rs);
    checks++;
    if (out_sum !== 28'h0000200 || out_count !== 5'd2) begin
      errors++;
      $display("FAIL reset_next_group: out_sum=%h out_count=%0d (required 0000200 2)", out_sum, out_count);
    end
    $display("reset mid group: next out_sum=%h out_count=%0d", out_sum, out_count);
    release_result();
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_single(12'h00F, 12'hFFF, 28'h0000000, "trunc_zero");
    test_single(12'h123, 12'h456, 28'h004DA00, "mid_value");
    test_last_early();
    test_hold_done();
    test_ready_early();
    test_reset_mid_group();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
